// File: rtl/mem_wb_pipe_reg.sv
// rtl/mem_wb_pipe_reg.sv - MEM->WB elastic pipeline register with write-back select, flush and x0 suppression
//
// Purpose:
//   Carries one resolved write-back entry per stage from the memory stage to the
//   register-file write port. The write-back source (ALU / load / U-UJ value) is
//   selected when the entry is captured, so downstream sees a single data word.
//   DEPTH stages (1..4) form an elastic queue with a valid/ready handshake on
//   both sides, full throughput and bubble collapsing under stall.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              synchronous kill of every held entry
//   in_valid/in_ready  upstream handshake
//   in_load_data       load data returned by memory
//   in_alu_res         ALU result
//   in_uj_val          U/UJ-type value (LUI/AUIPC/JAL link)
//   in_rd, in_wb_en    destination register and write enable
//   in_wb_sel          00 ALU, 01 load, 10 U/UJ, 11 ALU
//   out_valid/out_ready downstream handshake
//   out_rd, out_wb_en, out_wb_data  head entry (rd/data read 0 when not valid)
//   occupancy          number of valid stages, 0..DEPTH

module mem_wb_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int DEPTH     = 1,
  parameter int ZERO_SUPP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic [XLEN-1:0] in_uj_val,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_wb_en,
  input  logic [1:0]      in_wb_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RA_W-1:0] out_rd,
  output logic            out_wb_en,
  output logic [XLEN-1:0] out_wb_data,
  output logic [2:0]      occupancy
);

  if ((DEPTH < 1) || (DEPTH > 4)) begin : g_depth_check
    $error("mem_wb_pipe_reg: DEPTH must be in 1..4");
  end

  // Stage storage; index DEPTH-1 is the head presented to WB.
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] wen_q;
  logic [RA_W-1:0]  rd_q   [DEPTH];
  logic [XLEN-1:0]  data_q [DEPTH];
  logic [2:0]       occ_q;

  // Per-stage load enable and the value each stage would load.
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] src_vld;
  logic [DEPTH-1:0] src_wen;
  logic [RA_W-1:0]  src_rd   [DEPTH];
  logic [XLEN-1:0]  src_data [DEPTH];

  logic [XLEN-1:0]  in_data;
  logic             acc;
  logic             leave;

  always_comb begin
    in_data = in_alu_res;
    case (in_wb_sel)
      2'b01:   in_data = in_load_data;
      2'b10:   in_data = in_uj_val;
      default: in_data = in_alu_res;
    endcase
  end

  // Stage k may load when it is empty or the stage after it moves on. Unrolled,
  // that chain reduces to: some stage from k to the head is empty, or the head
  // is being consumed. Written flat to keep the logic free of a ripple loop.
  always_comb begin
    logic full;
    full = 1'b1;
    ld   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      full = 1'b1;
      for (int j = k; j < DEPTH; j++) begin
        full = full & vld[j];
      end
      ld[k] = !full || out_ready;
    end
  end

  always_comb begin
    src_vld = '0;
    src_wen = '0;
    for (int k = 0; k < DEPTH; k++) begin
      src_rd[k]   = '0;
      src_data[k] = '0;
    end
    src_vld[0]  = in_valid;
    src_wen[0]  = in_wb_en;
    src_rd[0]   = in_rd;
    src_data[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_vld[k]  = vld[k-1];
      src_wen[k]  = wen_q[k-1];
      src_rd[k]   = rd_q[k-1];
      src_data[k] = data_q[k-1];
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[DEPTH-1];
  assign acc       = in_valid && ld[0];
  assign leave     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= '0;
      wen_q <= '0;
      occ_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          vld[k]    <= src_vld[k];
          wen_q[k]  <= src_wen[k];
          rd_q[k]   <= src_rd[k];
          data_q[k] <= src_data[k];
        end
      end
      // Flush overrides any load, including a same-cycle input entry. A head
      // handshake in that cycle has already been seen by WB, so it retires.
      if (flush) begin
        vld   <= '0;
        occ_q <= '0;
      end else begin
        occ_q <= occ_q + {2'b00, acc} - {2'b00, leave};
      end
    end
  end

  assign out_rd      = out_valid ? rd_q[DEPTH-1] : '0;
  assign out_wb_data = out_valid ? data_q[DEPTH-1] : '0;
  assign out_wb_en   = out_valid && wen_q[DEPTH-1] &&
                       !((ZERO_SUPP != 0) && (rd_q[DEPTH-1] == '0));
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb/tb_mem_wb_pipe_reg.sv - scoreboard bench for mem_wb_pipe_reg over DEPTH 1..4 and both ZERO_SUPP settings

module tb_mem_wb_pipe_reg;

  localparam int NI = 4;
  localparam int DEP [NI] = '{1, 2, 3, 4};
  localparam int ZSP [NI] = '{1, 0, 1, 0};

  localparam int K_OCC   = 0;
  localparam int K_IRDY  = 1;
  localparam int K_OVLD  = 2;
  localparam int K_WBEN  = 3;
  localparam int K_DATA  = 4;
  localparam int K_RD    = 5;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_load;
  logic [31:0] in_alu;
  logic [31:0] in_uj;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic [1:0]  in_sel;
  logic [NI-1:0] out_ready;

  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_wb_en;
  logic [4:0]    out_rd   [NI];
  logic [31:0]   out_data [NI];
  logic [2:0]    occ      [NI];

  typedef struct {
    logic [4:0]  rd;
    logic        wb_en;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          kind;
    int          g;
    logic [31:0] val;
  } dexp_t;

  exp_t  q [NI][$];
  dexp_t dq[$];

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_wb_pipe_reg #(
      .XLEN(32), .RA_W(5), .DEPTH(DEP[g]), .ZERO_SUPP(ZSP[g])
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready[g]),
      .in_load_data (in_load),
      .in_alu_res   (in_alu),
      .in_uj_val    (in_uj),
      .in_rd        (in_rd),
      .in_wb_en     (in_wb_en),
      .in_wb_sel    (in_sel),
      .out_valid    (out_valid[g]),
      .out_ready    (out_ready[g]),
      .out_rd       (out_rd[g]),
      .out_wb_en    (out_wb_en[g]),
      .out_wb_data  (out_data[g]),
      .occupancy    (occ[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected write-back entry for the inputs currently driven.
  function automatic exp_t model(int g);
    exp_t e;
    e.rd    = in_rd;
    e.wb_en = in_wb_en && !((ZSP[g] != 0) && (in_rd == 5'd0));
    case (in_sel)
      2'b01:   e.data = in_load;
      2'b10:   e.data = in_uj;
      default: e.data = in_alu;
    endcase
    return e;
  endfunction

  task automatic check(string nm, int g, logic [31:0] act, logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s dut%0d(DEPTH=%0d): got %h want %h", nm, g, DEP[g], act, want);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (run) begin
      for (int g = 0; g < NI; g++) begin
        int   sz;
        exp_t e;
        sz = q[g].size();
        check("occupancy", g, 32'(occ[g]), sz);
        check("in_ready", g, 32'(in_ready[g]), 32'((sz < DEP[g]) || out_ready[g]));
        if (out_valid[g]) begin
          if (sz == 0) begin
            check("spurious_out_valid", g, 32'(out_valid[g]), 32'd0);
          end else begin
            e = q[g][0];
            check("out_rd", g, 32'(out_rd[g]), 32'(e.rd));
            check("out_wb_en", g, 32'(out_wb_en[g]), 32'(e.wb_en));
            check("out_wb_data", g, out_data[g], e.data);
            if (out_ready[g]) void'(q[g].pop_front());
          end
        end else begin
          check("idle_rd", g, 32'(out_rd[g]), 32'd0);
          check("idle_data", g, out_data[g], 32'd0);
          check("idle_wb_en", g, 32'(out_wb_en[g]), 32'd0);
        end
      end
      while (dq.size() > 0) begin
        dexp_t d;
        d = dq.pop_front();
        case (d.kind)
          K_OCC:   check("dir_occupancy", d.g, 32'(occ[d.g]), d.val);
          K_IRDY:  check("dir_in_ready", d.g, 32'(in_ready[d.g]), d.val);
          K_OVLD:  check("dir_out_valid", d.g, 32'(out_valid[d.g]), d.val);
          K_WBEN:  check("dir_out_wb_en", d.g, 32'(out_wb_en[d.g]), d.val);
          K_DATA:  check("dir_out_wb_data", d.g, out_data[d.g], d.val);
          default: check("dir_out_rd", d.g, 32'(out_rd[d.g]), d.val);
        endcase
      end
    end
  end

  task automatic expect_at_next(int kind, int g, logic [31:0] val);
    dexp_t d;
    d.kind = kind;
    d.g    = g;
    d.val  = val;
    dq.push_back(d);
  endtask

  // One clock: sample handshakes before the edge, update the scoreboard at the edge.
  task automatic step();
    bit acc [NI];
    bit fl;
    @(negedge clk);
    fl = flush;
    for (int g = 0; g < NI; g++) acc[g] = in_valid && in_ready[g];
    @(posedge clk);
    for (int g = 0; g < NI; g++) begin
      if (fl) q[g].delete();
      else if (acc[g]) q[g].push_back(model(g));
    end
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] sel, logic [4:0] rd, logic we,
                       logic [31:0] alu, logic [31:0] ld, logic [31:0] uj);
    in_valid = v;
    in_sel   = sel;
    in_rd    = rd;
    in_wb_en = we;
    in_alu   = alu;
    in_load  = ld;
    in_uj    = uj;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = '1;
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run   = 1'b1;

    // Reset state.
    for (int g = 0; g < NI; g++) begin
      expect_at_next(K_OCC, g, 32'd0);
      expect_at_next(K_OVLD, g, 32'd0);
      expect_at_next(K_WBEN, g, 32'd0);
      expect_at_next(K_DATA, g, 32'd0);
    end
    step();

    // Latency: out_valid exactly DEPTH edges after accept on an empty pipe.
    drive(1'b1, 2'b00, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      for (int g = 0; g < NI; g++) begin
        expect_at_next(K_OVLD, g, 32'(c == DEP[g]));
        if (c == DEP[g]) begin
          expect_at_next(K_DATA, g, 32'h1234);
          expect_at_next(K_RD, g, 32'd5);
          expect_at_next(K_WBEN, g, 32'd1);
        end
      end
      step();
    end

    // Mux selections and x0 suppression, back to back.
    drive(1'b1, 2'b01, 5'd7, 1'b1, 32'h1111, 32'hDEADBEEF, 32'h2222); step();
    drive(1'b1, 2'b10, 5'd8, 1'b1, 32'h3333, 32'h4444, 32'h00010000); step();
    drive(1'b1, 2'b11, 5'd9, 1'b1, 32'hA5A5A5A5, 32'h5555, 32'h6666); step();
    drive(1'b1, 2'b00, 5'd0, 1'b1, 32'h77, 32'h0, 32'h0); step();
    in_valid = 1'b0;
    repeat (6) step();

    // Stall: four pushes with the head blocked.
    out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 5'(10 + i), 1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i));
      step();
    end
    for (int g = 0; g < NI; g++) begin
      expect_at_next(K_OCC, g, 32'((DEP[g] < 4) ? DEP[g] : 4));
      expect_at_next(K_IRDY, g, 32'd0);
    end
    step();
    in_valid  = 1'b0;
    out_ready = '1;
    repeat (6) step();

    // Flush with a same-cycle input and a same-cycle head handshake.
    out_ready = '0;
    drive(1'b1, 2'b00, 5'd20, 1'b1, 32'hAAAA0001, 32'h0, 32'h0); step();
    drive(1'b1, 2'b00, 5'd21, 1'b1, 32'hAAAA0002, 32'h0, 32'h0); step();
    drive(1'b1, 2'b00, 5'd22, 1'b1, 32'hAAAA0003, 32'h0, 32'h0);
    flush     = 1'b1;
    out_ready = '1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int g = 0; g < NI; g++) begin
      expect_at_next(K_OCC, g, 32'd0);
      expect_at_next(K_OVLD, g, 32'd0);
    end
    step();

    // Asynchronous reset in the middle of a stall.
    out_ready = '0;
    drive(1'b1, 2'b00, 5'd3, 1'b1, 32'hBBBB0001, 32'h0, 32'h0); step();
    drive(1'b1, 2'b00, 5'd4, 1'b1, 32'hBBBB0002, 32'h0, 32'h0); step();
    in_valid = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      q[g].delete();
      expect_at_next(K_OCC, g, 32'd0);
      expect_at_next(K_OVLD, g, 32'd0);
      expect_at_next(K_WBEN, g, 32'd0);
      expect_at_next(K_DATA, g, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = '1;
    step();

    // Randomized traffic with per-instance backpressure and occasional flush.
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom),
            (($urandom % 8) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), $urandom, $urandom, $urandom);
      for (int g = 0; g < NI; g++) out_ready[g] = ($urandom % 10) < 7;
      flush = ($urandom % 50) == 0;
      step();
    end

    // Drain with a bounded budget, then require every pipe empty.
    drive(1'b0, 2'b00, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    flush     = 1'b0;
    out_ready = '1;
    repeat (10) step();
    for (int g = 0; g < NI; g++) begin
      expect_at_next(K_OCC, g, 32'd0);
      expect_at_next(K_OVLD, g, 32'd0);
    end
    step();
    run = 1'b0;
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
